sprite_blitter: RTL

//  Generic ROM-to-VGA image blitter: on a start pulse, walks an IMG_W x IMG_H image ROM row-major,

---
 rtl/vga_pkg.sv | 24 ++
 rtl/blit_delay_pipe.sv | 26 ++
 rtl/sprite_blitter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry, coordinate/colour widths, blitter state encoding.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 9;

  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

  // Address width for an n-word ROM; a single-word image still needs one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_delay_pipe.sv
// Fixed-depth shift register that carries {valid, col, row} alongside the ROM read latency.
module blit_delay_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  // Shift one stage per cycle; reset empties the pipe so no stale pixel can plot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// ROM-to-VGA image blitter with run-time origin, screen clipping and optional colour key.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; origin latched on accept
// ST_RUN   | one ROM address issued per cycle, row-major
// ST_FLUSH | all addresses issued; waiting for the last pixel to leave pipe
// ST_DONE  | one-cycle done pulse, then back to idle
module sprite_blitter #(
  parameter int   IMG_W       = 160,
  parameter int   IMG_H       = 120,
  parameter int   SCREEN_W    = vga_pkg::SCREEN_W,
  parameter int   SCREEN_H    = vga_pkg::SCREEN_H,
  parameter int   X_W         = vga_pkg::X_W,
  parameter int   Y_W         = vga_pkg::Y_W,
  parameter int   COLOUR_W    = vga_pkg::COLOUR_W,
  parameter int   ROM_LATENCY = 1,
  parameter bit   TRANSP_EN   = 1'b0,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY = 9'h1FF,
  localparam int  ADDR_W      = vga_pkg::addr_width(IMG_W * IMG_H)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  import vga_pkg::*;

  localparam int FC_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int PW   = 1 + X_W + Y_W;

  blit_state_t         state;
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [X_W-1:0]      col;
  logic [Y_W-1:0]      row;
  logic [ADDR_W-1:0]   addr;
  logic [FC_W-1:0]     flush_cnt;
  logic                last_pix;
  logic [PW-1:0]       pipe_in;
  logic [PW-1:0]       pipe_out;
  logic                p_valid;
  logic [X_W-1:0]      p_col;
  logic [Y_W-1:0]      p_row;
  logic [X_W:0]        px;
  logic [Y_W:0]        py;
  logic                on_screen;
  logic                transparent;

  assign last_pix = (col == X_W'(IMG_W - 1)) && (row == Y_W'(IMG_H - 1));
  assign rom_addr = addr;

  // Walk the image once per start; flush_cnt counts down the ROM latency after the last issue.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x0_q  <= x0;
            y0_q  <= y0;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_pix) begin
            flush_cnt <= FC_W'(ROM_LATENCY - 1);
            state     <= ST_FLUSH;
          end else begin
            addr <= addr + 1'b1;
            if (col == X_W'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Coordinates travel with the ROM read so they line up with rom_q at the output.
  assign pipe_in = {(state == ST_RUN), col, row};

  blit_delay_pipe #(
    .DEPTH (ROM_LATENCY),
    .W     (PW)
  ) u_pipe (
    .clk    (clk),
    .resetn (resetn),
    .din    (pipe_in),
    .dout   (pipe_out)
  );

  assign {p_valid, p_col, p_row} = pipe_out;

  // One extra bit on each sum so an origin near the edge clips instead of wrapping.
  assign px          = {1'b0, x0_q} + {1'b0, p_col};
  assign py          = {1'b0, y0_q} + {1'b0, p_row};
  assign on_screen   = (px < (X_W + 1)'(SCREEN_W)) && (py < (Y_W + 1)'(SCREEN_H));
  assign transparent = TRANSP_EN && (rom_q == TRANSP_KEY);

  assign plot   = p_valid && on_screen && !transparent;
  assign x      = px[X_W-1:0];
  assign y      = py[Y_W-1:0];
  assign colour = rom_q;

endmodule
